// File: rtl/ser64_wr.sv
// Serial-to-parallel writer: 64 strobed bits fill a 16 x 4-bit register file, read out combinationally.
// Latency: one tick per accepted bit; done pulses the cycle after the edge that takes bit 64.
// Backpressure: none; sdi_vld outside a frame is dropped and flagged on the sticky ovr bit.
module ser64_wr #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       tick,
  input  logic       clr,
  input  logic       start,
  input  logic       sdi,
  input  logic       sdi_vld,
  input  logic [3:0] rd_a,
  output logic [3:0] rd_d,
  output logic [3:0] rg_a,
  output logic [1:0] bit_a,
  output logic       busy,
  output logic       done,
  output logic       ovr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [5:0] ptr, ptr_nxt;
  logic       ovr_nxt;
  logic       wr_en;
  logic [1:0] wr_bit;
  logic [3:0] mem [16];

  // Control registers: FSM state, write pointer and sticky overrun flag.
  always_ff @(posedge tick) begin
    if (clr) begin
      state <= IDLE;
      ptr   <= 6'd0;
      ovr   <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      ovr   <= ovr_nxt;
    end
  end

  // Next-state logic: frame start, bit acceptance with pointer advance, stray-strobe detection.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    ovr_nxt   = ovr;
    wr_en     = 1'b0;
    case (state)
      IDLE: begin
        // A strobe coinciding with an accepted start is simply ignored.
        if (start) begin
          state_nxt = RECV;
          ptr_nxt   = 6'd0;
          ovr_nxt   = 1'b0;
        end else if (sdi_vld) begin
          ovr_nxt = 1'b1;
        end
      end
      RECV: begin
        // start is deliberately not looked at here so a running frame cannot restart.
        if (sdi_vld) begin
          wr_en   = 1'b1;
          ptr_nxt = ptr + 6'd1;  // wraps 63 -> 0 on the last bit
          if (ptr == 6'd63) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        if (sdi_vld) begin
          ovr_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Bit position inside the nibble; MSB_FIRST mirrors it so the first bit lands in bit 3.
  assign wr_bit = MSB_FIRST ? ~ptr[1:0] : ptr[1:0];

  // Register file: cleared by clr, otherwise exactly one bit written per accepted strobe.
  always_ff @(posedge tick) begin
    if (clr) begin
      for (int i = 0; i < 16; i++) begin
        mem[i] <= 4'h0;
      end
    end else if (wr_en) begin
      mem[ptr[5:2]][wr_bit] <= sdi;
    end
  end

  // Read port is purely combinational, so a same-cycle write shows up only after the edge.
  assign rd_d  = mem[rd_a];
  assign rg_a  = ptr[5:2];
  assign bit_a = ptr[1:0];
  assign busy  = (state == RECV);
  assign done  = (state == DONE);

endmodule

// File: doc/ser64_wr.md
SER64_WR -- requirements
Module: ser64_wr

Interface
REQ-001 Parameter MSB_FIRST, default 0, SHALL select in-nibble bit order: 0 means the bit at index bit_a goes to nibble bit bit_a; 1 means it goes to nibble bit 3-bit_a.
REQ-002 tick  in  1  SHALL be the sole clock; every register updates on its rising edge.
REQ-003 clr  in  1  SHALL be the reset: synchronous, active-high.
REQ-004 start  in  1  SHALL be the frame-start request, sampled in IDLE only.
REQ-005 sdi  in  1  SHALL be the serial data bit.
REQ-006 sdi_vld  in  1  SHALL be the strobe qualifying sdi for the current cycle.
REQ-007 rd_a  in  4  SHALL be the read-port register address.
REQ-008 rd_d  out  4  SHALL be the read data: combinational, equal to mem[rd_a].
REQ-009 rg_a  out  4  SHALL be the current write register address, equal to ptr[5:2].
REQ-010 bit_a  out  2  SHALL be the current write bit address, equal to ptr[1:0].
REQ-011 busy  out  1  SHALL be high while in RECV.
REQ-012 done  out  1  SHALL be a one-cycle pulse, high while in DONE.
REQ-013 ovr  out  1  SHALL be a sticky flag marking a stray strobe.

Function
REQ-014 Storage SHALL be 16 registers of 4 bits (mem[0..15], 64 bits total), addressed by a 6-bit write pointer ptr.
REQ-015 The FSM SHALL have three states: IDLE, RECV, DONE.
REQ-016 IDLE with start=1 SHALL move to RECV next cycle, load ptr=0, and clear ovr.
  - Any sdi_vld in that same cycle SHALL be ignored and SHALL NOT set ovr.
REQ-017 In RECV, each cycle with sdi_vld=1 SHALL write sdi into mem[ptr[5:2]] at the bit position set by REQ-001, then increment ptr by 1.
  - Cycles with sdi_vld=0 SHALL leave ptr and mem unchanged.
REQ-018 In RECV with ptr=63 and sdi_vld=1, the block SHALL write the bit, wrap ptr to 0, and move to DONE.
REQ-019 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-020 start SHALL be ignored in RECV and DONE; a frame in progress is not restarted.
REQ-021 sdi_vld=1 in IDLE (without start) or in DONE SHALL set ovr=1, and SHALL NOT change mem or ptr.
REQ-022 ovr SHALL stay set until clr, or until start is accepted in IDLE.
REQ-023 A single write SHALL modify exactly one bit of mem; the other 63 bits SHALL hold their values.
REQ-024 Read-during-write (rd_a equal to the register being written): rd_d SHALL show the old value in that cycle and the new value from the next cycle.
REQ-025 Frame latency: done SHALL assert in the cycle after the edge that accepts the 64th strobed bit.
REQ-026 mem contents SHALL persist across frames and while idle; a new frame SHALL overwrite only the bits it receives.

Reset
REQ-027 With clr=1 at a rising edge of tick, the block SHALL load: state=IDLE, ptr=0, all 16 mem registers=0, busy=0, done=0, ovr=0.
REQ-028 clr SHALL take priority over start and sdi_vld in the same cycle.
REQ-029 clr during RECV SHALL abort the frame with no done pulse.
REQ-030 Whenever clr is low, rd_d SHALL stay combinational from mem.

Verification
REQ-031 Full frame: clr, start, then 64 consecutive strobes of pattern 0x0123456789ABCDEF sent LSB-first, MSB_FIRST=0 -> done pulses exactly once, in the cycle after bit 64; rd_a=0 reads 0xF, rd_a=15 reads 0x0; ptr=0 afterwards.
REQ-032 Gapped strobes: 64 bits of all ones with sdi_vld low every other cycle -> busy high for 127 cycles, rg_a/bit_a advance only on strobes, every register reads 0xF.
REQ-033 Stray strobe: sdi_vld=1 in IDLE -> ovr=1 and mem unchanged; following start -> ovr=0.
REQ-034 Mid-frame reset: clr asserted after 20 bits -> next cycle busy=0, done=0, rg_a=0, bit_a=0, all registers read 0x0; no done pulse follows.
REQ-035 Bit order: MSB_FIRST=1, frame of a single 1 followed by 63 zeros -> register 0 reads 0x8, all others read 0x0.
REQ-036 Start during RECV and read-during-write: start pulsed at bit 30 -> ptr continues to 31; rd_a held at the active register -> rd_d updates one cycle after each write.
